// File: rtl/batpu_pkg.sv
// Purpose: shared BatPU2 decode types (opcodes, branch conditions, decoded bundle).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package batpu_pkg;

    localparam int PC_W_DEF   = 10;
    localparam int INST_W_DEF = 16;

    // r0 reads as zero and discards writes.
    localparam logic [3:0] REG_ZERO = 4'h0;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_HLT = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_NOR = 4'h4,
        OP_AND = 4'h5,
        OP_XOR = 4'h6,
        OP_RSH = 4'h7,
        OP_LDI = 4'h8,
        OP_ADI = 4'h9,
        OP_JMP = 4'hA,
        OP_BRH = 4'hB,
        OP_CAL = 4'hC,
        OP_RET = 4'hD,
        OP_LOD = 4'hE,
        OP_STR = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        COND_ZERO   = 2'd0,
        COND_NZERO  = 2'd1,
        COND_CARRY  = 2'd2,
        COND_NCARRY = 2'd3
    } cond_t;

    typedef struct packed {
        opcode_t               opcode;
        logic [3:0]            dst;
        logic [3:0]            src_a;
        logic [3:0]            src_b;
        logic                  we;
        logic [7:0]            imm8;
        logic [3:0]            offset;
        cond_t                 cond;
        logic [PC_W_DEF-1:0]   addr;
        logic [PC_W_DEF-1:0]   pc;
    } decoded_t;

    // Two-register-source ALU group (ADD..XOR); RSH is handled separately.
    function automatic logic is_alu2(input opcode_t op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_NOR) ||
               (op == OP_AND) || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/inst_field_decoder.sv
// Purpose: split a BatPU2 instruction word into a decoded_t bundle plus source-read flags.
// Latency: combinational.
// Backpressure: none; pure function of inst/pc.
//
// Ports: inst (instruction word), pc (its PC) -> dec (field bundle),
//        reads_a / reads_b (instruction actually consumes src_a / src_b).
module inst_field_decoder
    import batpu_pkg::*;
(
    input  logic [INST_W_DEF-1:0] inst,
    input  logic [PC_W_DEF-1:0]   pc,
    output decoded_t              dec,
    output logic                  reads_a,
    output logic                  reads_b
);

    opcode_t op;
    logic    we_raw;

    assign op = opcode_t'(inst[15:12]);

    always_comb begin
        dec        = '0;
        reads_a    = 1'b0;
        reads_b    = 1'b0;
        we_raw     = 1'b0;
        dec.opcode = op;
        dec.pc     = pc;

        if (is_alu2(op)) begin
            dec.src_a = inst[11:8];
            dec.src_b = inst[7:4];
            dec.dst   = inst[3:0];
            we_raw    = 1'b1;
            reads_a   = 1'b1;
            reads_b   = 1'b1;
        end else begin
            case (op)
                OP_RSH: begin
                    dec.src_a = inst[11:8];
                    dec.dst   = inst[3:0];
                    we_raw    = 1'b1;
                    reads_a   = 1'b1;
                end
                OP_LDI: begin
                    dec.dst  = inst[11:8];
                    dec.imm8 = inst[7:0];
                    we_raw   = 1'b1;
                end
                OP_ADI: begin
                    // Accumulate-immediate: the destination is also the source.
                    dec.dst   = inst[11:8];
                    dec.src_a = inst[11:8];
                    dec.imm8  = inst[7:0];
                    we_raw    = 1'b1;
                    reads_a   = 1'b1;
                end
                OP_JMP, OP_CAL: begin
                    dec.addr = inst[PC_W_DEF-1:0];
                end
                OP_BRH: begin
                    dec.cond = cond_t'(inst[11:10]);
                    dec.addr = inst[PC_W_DEF-1:0];
                end
                OP_LOD: begin
                    dec.src_a  = inst[11:8];
                    dec.dst    = inst[7:4];
                    dec.offset = inst[3:0];
                    we_raw     = 1'b1;
                    reads_a    = 1'b1;
                end
                OP_STR: begin
                    dec.src_a  = inst[11:8];
                    dec.src_b  = inst[7:4];
                    dec.offset = inst[3:0];
                    reads_a    = 1'b1;
                    reads_b    = 1'b1;
                end
                default: begin
                    // NOP, HLT, RET and the ALU group: no fields here.
                end
            endcase
        end

        // Writes to r0 are dropped at decode so later stages never see them.
        dec.we = we_raw && (dec.dst != REG_ZERO);
    end

endmodule

// File: rtl/decode_stage.sv
// Purpose: BatPU2 decode stage - registered field split, load-use bubble, sticky halt, flush squash.
// Latency: one cycle from acceptance to bundle on outputs.
// Backpressure: stall_in holds the output register; hold_fetch stops fetch on hazard, stall or halt.
//
// Ports: clk/rst_n/clk_en; inst_in, pc_in, in_valid from fetch; stall_in, flush from downstream;
//        hold_fetch to fetch; out_valid + opcode/dst/src_a/src_b/we/imm8/offset/cond/addr/pc_out
//        bundle to register-read; halted is the sticky HLT flag.
module decode_stage
    import batpu_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int INST_W = INST_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic [INST_W-1:0] inst_in,
    input  logic [PC_W-1:0]   pc_in,
    input  logic              in_valid,
    input  logic              stall_in,
    input  logic              flush,
    output logic              hold_fetch,
    output logic              out_valid,
    output logic [3:0]        opcode,
    output logic [3:0]        dst,
    output logic [3:0]        src_a,
    output logic [3:0]        src_b,
    output logic              we,
    output logic [7:0]        imm8,
    output logic [3:0]        offset,
    output logic [1:0]        cond,
    output logic [PC_W-1:0]   addr,
    output logic [PC_W-1:0]   pc_out,
    output logic              halted
);

    decoded_t dec;
    decoded_t bundle_q;
    logic     valid_q;
    logic     halted_q;
    logic     reads_a;
    logic     reads_b;
    logic     load_use;
    logic     hazard;

    inst_field_decoder u_field_decoder (
        .inst    (inst_in),
        .pc      (pc_in),
        .dec     (dec),
        .reads_a (reads_a),
        .reads_b (reads_b)
    );

    // The loaded value is not available until one cycle after LOD leaves decode,
    // so a consumer directly behind it must wait one slot. r0 never matches
    // because a LOD to r0 writes nothing.
    always_comb begin
        load_use = valid_q && (bundle_q.opcode == OP_LOD) &&
                   (bundle_q.dst != REG_ZERO) && in_valid &&
                   ((reads_a && (dec.src_a == bundle_q.dst)) ||
                    (reads_b && (dec.src_b == bundle_q.dst)));
        // A flush discards the consumer anyway, so no reason to hold fetch for it.
        hazard = load_use && !flush;
    end

    assign hold_fetch = hazard || stall_in || halted_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bundle_q <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else if (clk_en) begin
            if (flush) begin
                // Squash wins over stall and hazard; a flushed HLT never halts.
                bundle_q <= '0;
                valid_q  <= 1'b0;
            end else if (!stall_in) begin
                if (halted_q || hazard || !in_valid) begin
                    bundle_q <= '0;
                    valid_q  <= 1'b0;
                end else begin
                    bundle_q <= dec;
                    valid_q  <= 1'b1;
                    if (dec.opcode == OP_HLT) begin
                        halted_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign out_valid = valid_q;
    assign opcode    = bundle_q.opcode;
    assign dst       = bundle_q.dst;
    assign src_a     = bundle_q.src_a;
    assign src_b     = bundle_q.src_b;
    assign we        = bundle_q.we;
    assign imm8      = bundle_q.imm8;
    assign offset    = bundle_q.offset;
    assign cond      = bundle_q.cond;
    assign addr      = bundle_q.addr;
    assign pc_out    = bundle_q.pc;
    assign halted    = halted_q;

endmodule

// File: tb/tb_decode_stage.sv
// Purpose: self-checking bench for decode_stage using an expected-bundle queue.
// Latency: expects each bundle one edge after its stimulus.
// Backpressure: exercises stall_in, flush, load-use hold and halt.
module tb_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        clk_en;
    logic [15:0] inst_in;
    logic [9:0]  pc_in;
    logic        in_valid;
    logic        stall_in;
    logic        flush;
    logic        hold_fetch;
    logic        out_valid;
    logic [3:0]  opcode;
    logic [3:0]  dst;
    logic [3:0]  src_a;
    logic [3:0]  src_b;
    logic        we;
    logic [7:0]  imm8;
    logic [3:0]  offset;
    logic [1:0]  cond;
    logic [9:0]  addr;
    logic [9:0]  pc_out;
    logic        halted;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] sb_q[$];

    decode_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_en     (clk_en),
        .inst_in    (inst_in),
        .pc_in      (pc_in),
        .in_valid   (in_valid),
        .stall_in   (stall_in),
        .flush      (flush),
        .hold_fetch (hold_fetch),
        .out_valid  (out_valid),
        .opcode     (opcode),
        .dst        (dst),
        .src_a      (src_a),
        .src_b      (src_b),
        .we         (we),
        .imm8       (imm8),
        .offset     (offset),
        .cond       (cond),
        .addr       (addr),
        .pc_out     (pc_out),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Packed view: {valid, halted, opcode, dst, src_a, src_b, we, imm8, offset, cond, addr, pc}
    function automatic logic [63:0] mk(input logic v, input logic h, input logic [3:0] op,
                                       input logic [3:0] d, input logic [3:0] a, input logic [3:0] b,
                                       input logic w, input logic [7:0] imm, input logic [3:0] off,
                                       input logic [1:0] cnd, input logic [9:0] ad, input logic [9:0] p);
        return {11'b0, v, h, op, d, a, b, w, imm, off, cnd, ad, p};
    endfunction

    function automatic logic [63:0] observed();
        return {11'b0, out_valid, halted, opcode, dst, src_a, src_b, we, imm8, offset, cond, addr, pc_out};
    endfunction

    function automatic logic [63:0] bubble(input logic h);
        return mk(1'b0, h, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 8'h00, 4'h0, 2'd0, 10'h000, 10'h000);
    endfunction

    // Drive one cycle of stimulus, check combinational hold_fetch, then
    // compare the bundle produced at the following edge.
    task automatic step(input string tag, input logic [15:0] i, input logic [9:0] p,
                        input logic v, input logic st, input logic fl, input logic ce,
                        input logic hold_exp, input logic [63:0] e);
        logic [63:0] exp_b;
        inst_in  = i;
        pc_in    = p;
        in_valid = v;
        stall_in = st;
        flush    = fl;
        clk_en   = ce;
        #1;
        check_eq({tag, "_hold"}, {63'b0, hold_fetch}, {63'b0, hold_exp});
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        exp_b = sb_q.pop_front();
        check_eq(tag, observed(), exp_b);
    endtask

    logic [63:0] e_adi;
    logic [63:0] e_sub;

    initial begin
        rst_n = 1'b0; clk_en = 1'b1; inst_in = '0; pc_in = '0;
        in_valid = 1'b0; stall_in = 1'b0; flush = 1'b0;
        #12;
        check_eq("reset_bundle", observed(), 64'h0);
        check_eq("reset_hold", {63'b0, hold_fetch}, 64'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Plain decode of each field layout.
        step("add",  16'h2123, 10'h005, 1, 0, 0, 1, 0, mk(1,0,4'h2,4'h3,4'h1,4'h2,1,8'h00,4'h0,2'd0,10'h000,10'h005));
        step("ldi",  16'h8A7F, 10'h006, 1, 0, 0, 1, 0, mk(1,0,4'h8,4'hA,4'h0,4'h0,1,8'h7F,4'h0,2'd0,10'h000,10'h006));
        step("brh",  16'hB9C4, 10'h007, 1, 0, 0, 1, 0, mk(1,0,4'hB,4'h0,4'h0,4'h0,0,8'h00,4'h0,2'd2,10'h1C4,10'h007));
        step("add_r0", 16'h2120, 10'h008, 1, 0, 0, 1, 0, mk(1,0,4'h2,4'h0,4'h1,4'h2,0,8'h00,4'h0,2'd0,10'h000,10'h008));

        // ADI then three stalled cycles: bundle must hold.
        e_adi = mk(1,0,4'h9,4'h3,4'h3,4'h0,1,8'h05,4'h0,2'd0,10'h000,10'h009);
        step("adi", 16'h9305, 10'h009, 1, 0, 0, 1, 0, e_adi);
        for (int k = 0; k < 3; k++) begin
            step($sformatf("stall%0d", k), 16'h2456, 10'h00A, 1, 1, 0, 1, 1, e_adi);
        end
        step("stall_release", 16'h2456, 10'h00A, 1, 0, 0, 1, 0, mk(1,0,4'h2,4'h6,4'h4,4'h5,1,8'h00,4'h0,2'd0,10'h000,10'h00A));

        // Load-use: exactly one bubble, then the consumer.
        step("lod",  16'hE15F, 10'h010, 1, 0, 0, 1, 0, mk(1,0,4'hE,4'h5,4'h1,4'h0,1,8'h00,4'hF,2'd0,10'h000,10'h010));
        step("lu_bubble", 16'h2512, 10'h011, 1, 0, 0, 1, 1, bubble(0));
        step("lu_add", 16'h2512, 10'h011, 1, 0, 0, 1, 0, mk(1,0,4'h2,4'h2,4'h5,4'h1,1,8'h00,4'h0,2'd0,10'h000,10'h011));

        // LOD to r0 never creates a hazard.
        step("lod_r0", 16'hE10F, 10'h012, 1, 0, 0, 1, 0, mk(1,0,4'hE,4'h0,4'h1,4'h0,0,8'h00,4'hF,2'd0,10'h000,10'h012));
        step("r0_nobubble", 16'h2012, 10'h013, 1, 0, 0, 1, 0, mk(1,0,4'h2,4'h2,4'h0,4'h1,1,8'h00,4'h0,2'd0,10'h000,10'h013));

        // Flush beats stall and hazard; flushed HLT does not halt.
        step("flush_stall", 16'h2345, 10'h014, 1, 1, 1, 1, 1, bubble(0));
        step("lod2", 16'hE15F, 10'h015, 1, 0, 0, 1, 0, mk(1,0,4'hE,4'h5,4'h1,4'h0,1,8'h00,4'hF,2'd0,10'h000,10'h015));
        step("flush_hazard", 16'h2512, 10'h016, 1, 0, 1, 1, 0, bubble(0));
        step("flush_hlt", 16'h1000, 10'h020, 1, 0, 1, 1, 0, bubble(0));

        // in_valid low loads a bubble.
        step("invalid", 16'h2123, 10'h021, 0, 0, 0, 1, 0, bubble(0));

        // clk_en low freezes state.
        e_sub = mk(1,0,4'h3,4'h6,4'h4,4'h5,1,8'h00,4'h0,2'd0,10'h000,10'h022);
        step("sub", 16'h3456, 10'h022, 1, 0, 0, 1, 0, e_sub);
        step("clk_en_off", 16'h2789, 10'h023, 1, 0, 0, 0, 0, e_sub);

        // Halt: emitted as valid, then bubbles with hold_fetch until reset.
        step("hlt", 16'h1000, 10'h024, 1, 0, 0, 1, 0, mk(1,1,4'h1,4'h0,4'h0,4'h0,0,8'h00,4'h0,2'd0,10'h000,10'h024));
        step("halted0", 16'h2123, 10'h025, 1, 0, 0, 1, 1, bubble(1));
        step("halted1", 16'h2456, 10'h026, 1, 0, 0, 1, 1, bubble(1));

        // Reset clears halt asynchronously.
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("halt_reset_bundle", observed(), 64'h0);
        check_eq("halt_reset_hold", {63'b0, hold_fetch}, 64'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step("post_reset_add", 16'h2123, 10'h026, 1, 0, 0, 1, 0, mk(1,0,4'h2,4'h3,4'h1,4'h2,1,8'h00,4'h0,2'd0,10'h000,10'h026));

        // Async reset mid-cycle with a valid bundle held under stall.
        stall_in = 1'b1;
        in_valid = 1'b0;
        #3;
        check_eq("pre_async_valid", {63'b0, out_valid}, 64'h1);
        rst_n = 1'b0;
        #1;
        check_eq("async_reset_bundle", observed(), 64'h0);
        stall_in = 1'b0;
        #1;
        check_eq("async_reset_hold", {63'b0, hold_fetch}, 64'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Second pipeline stage of the BatPU2 core; sits directly downstream of instruction fetch.
- Takes the 16-bit word returned by instruction ROM plus the fetch PC.
- Produces a registered, field-split instruction bundle for register-read/execute.
- Detects load-use hazards and requests a fetch hold; latches HLT as a sticky halt; squashes on redirect.

Parameters:
- PC_W, 10, width of program counter / jump address
- INST_W, 16, instruction width (fixed ISA; not meant to be overridden)

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- clk_en  input  1  global stage enable; when 0, all state holds
- inst_in  input  16  instruction word from ROM for pc_in
- pc_in  input  10  PC of inst_in (fetch to_pipe)
- in_valid  input  1  inst_in/pc_in carry a real instruction
- stall_in  input  1  downstream cannot accept; hold output register
- flush  input  1  taken jump/branch/call/ret resolved downstream; squash
- hold_fetch  output  1  fetch must not advance (hazard, stall_in, or halted)
- out_valid  output  1  bundle below is a real instruction
- opcode  output  4  decoded opcode
- dst  output  4  destination register
- src_a  output  4  first source register
- src_b  output  4  second source register
- we  output  1  instruction writes dst
- imm8  output  8  LDI/ADI immediate
- offset  output  4  LOD/STR signed offset, raw
- cond  output  2  BRH condition
- addr  output  10  JMP/BRH/CAL target
- pc_out  output  10  PC of bundle
- halted  output  1  sticky HLT seen

Behaviour:
- Reset (async, rst_n=0): every output register 0; out_valid=0; halted=0; hold_fetch=0.
- Opcode map: 0 NOP,1 HLT,2 ADD,3 SUB,4 NOR,5 AND,6 XOR,7 RSH,8 LDI,9 ADI,A JMP,B BRH,C CAL,D RET,E LOD,F STR.
- Field split (inst[15:12]=opcode):
  - ALU 2..6: src_a=[11:8], src_b=[7:4], dst=[3:0], we=1.
  - RSH: src_a=[11:8], src_b=0, dst=[3:0], we=1.
  - LDI: dst=[11:8], imm8=[7:0], src_a=src_b=0, we=1.
  - ADI: dst=src_a=[11:8], imm8=[7:0], we=1.
  - JMP/CAL: addr=[9:0]. BRH: cond=[11:10], addr=[9:0].
  - LOD: src_a=[11:8] base, dst=[7:4], offset=[3:0], we=1.
  - STR: src_a=[11:8] base, src_b=[7:4] data, offset=[3:0], we=0.
  - All unused fields 0.
- we forced 0 when dst=0 (r0 is hard zero).
- Latency: one cycle; bundle for inst_in appears on outputs the edge after acceptance.
- Acceptance: register loads when clk_en=1 and stall_in=0.
- Load-use hazard (combinational): out_valid=1, opcode=LOD, dst!=0, and current in_valid instruction reads dst through src_a or src_b (read usage per field table; r0 never matches).
  - On hazard: register loads a bubble (out_valid=0, fields 0), hold_fetch=1, same inst_in re-presented next cycle.
  - Hazard clears after exactly one bubble.
- hold_fetch = hazard | stall_in | halted.
- flush (highest priority):
  - Next edge (clk_en=1) loads bubble regardless of stall_in/hazard.
  - hold_fetch is not asserted by hazard while flush=1.
  - A HLT in the flushed slot does not set halted.
- Halt:
  - Accepted HLT emits as a valid bundle and sets halted on the same edge.
  - Thereafter all loads are bubbles and hold_fetch=1 until reset.
- stall_in=1 with no flush: all registers hold, including halted.
- clk_en=0: all state holds; combinational hold_fetch still valid.
- in_valid=0: loads bubble (no hazard possible).

Decomposition:
- batpu_pkg:
  - opcode_t enum (16 values above).
  - cond_t enum (ZERO, NZERO, CARRY, NCARRY).
  - decoded_t struct (opcode, dst, src_a, src_b, we, imm8, offset, cond, addr, pc).
  - Constant REG_ZERO=4'h0.
- One combinational sub-module inst_field_decoder (inst word -> decoded_t plus reads_a/reads_b flags); the stage module owns the register, hazard, flush and halt logic.

Test Plan:
- Reset: rst_n low mid-stream with valid bundle held -> all outputs 0 immediately (async), halted=0.
- Decode: inst 0x2123 pc 0x005 -> next cycle opcode=2, src_a=1, src_b=2, dst=3, we=1, pc_out=0x005, out_valid=1; inst 0x8A7F -> dst=A, imm8=0x7F; inst 0xB9C4 -> cond=2, addr=0x1C4; inst 0x2120 -> we=0.
- Load-use: LOD 0xE15F then ADD 0x2512 -> one bubble cycle, hold_fetch=1 for that cycle, ADD emitted following cycle; LOD to r0 (0xE10F) then 0x2012 -> no bubble.
- Flush: flush=1 with valid ADD on inst_in and stall_in=1 -> next bundle out_valid=0; flush with HLT on inst_in -> halted stays 0.
- Stall: stall_in=1 for 3 cycles with bundle 0x9305 held -> outputs unchanged, hold_fetch=1; release -> next inst accepted.
- Halt: HLT 0x1000 accepted -> out_valid=1 opcode=1 and halted=1 same edge; subsequent valid inputs produce bubbles, hold_fetch=1 until rst_n pulses.
